// File: rtl/demixer_decim.sv
// -----------------------------------------------------------------------------
// demixer_decim
//
// Receive-side fs/4 demixer with integrate-and-dump decimation.
//
// Each accepted input sample is multiplied by a local oscillator running at a
// quarter of the sample rate. The LO sequence is +1, 0, -1, 0. The products are
// summed over a block of DECIM samples. The block sum, scaled down by
// DECIM/2, becomes one baseband sample. A cosine input in phase with the LO
// therefore comes out at unity gain.
//
// The result sits in a one-entry holding register with a valid/ready
// handshake. If a new result arrives while the held one is still unconsumed,
// the held result is overwritten and a sticky overrun flag is set.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   sample_i   in   W   signed input sample, qualified by in_valid
//   in_valid   in   1   sample_i is valid this cycle (always accepted)
//   sync_i     in   1   restart LO phase and decimation block
//   bb_o       out  W   signed decimated baseband sample
//   out_valid  out  1   bb_o holds an unconsumed result
//   out_ready  in   1   consumer takes bb_o on out_valid && out_ready
//   overrun_o  out  1   sticky: an unconsumed result was overwritten
// -----------------------------------------------------------------------------
module demixer_decim #(
    parameter int W          = 15,
    parameter int LOG2_DECIM = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] sample_i,
    input  logic                in_valid,
    input  logic                sync_i,
    output logic signed [W-1:0] bb_o,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun_o
);

    localparam int DECIM = 2 ** LOG2_DECIM;
    localparam int PW    = W + 1;               // product width: -(-2**(W-1)) fits
    localparam int AW    = W + 1 + LOG2_DECIM;  // accumulator width: cannot overflow

    // LO phase. The encoding is the phase index, so wrapping 3->0 is a 2-bit add.
    typedef enum logic [1:0] {
        PH_POS  = 2'd0,   // LO = +1
        PH_ZERO = 2'd1,   // LO =  0
        PH_NEG  = 2'd2,   // LO = -1
        PH_ZER3 = 2'd3    // LO =  0
    } phase_t;

    phase_t                      phase;
    logic    [LOG2_DECIM-1:0]    cnt;
    logic signed [AW-1:0]        acc;

    logic signed [PW-1:0]        sample_ext;
    logic signed [PW-1:0]        prod;
    logic signed [AW-1:0]        prod_ext;
    logic signed [AW-1:0]        result;
    logic                        last;
    logic                        load;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves
        // a signal unassigned and a latch is never inferred.
        prod       = '0;
        sample_ext = {sample_i[W-1], sample_i};
        case (phase)
            PH_POS:  prod = sample_ext;
            PH_NEG:  prod = -sample_ext;
            default: prod = '0;
        endcase
        prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
        result   = acc + prod_ext;
        last     = (cnt == LOG2_DECIM'(DECIM - 1));
        // sync_i discards the block in progress, so a sync sample never dumps.
        load     = in_valid && !sync_i && last;
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from the values they had before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_POS;
            cnt       <= '0;
            acc       <= '0;
            bb_o      <= '0;
            out_valid <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            // Phase, block counter and integrator.
            if (sync_i && in_valid) begin
                // This sample opens a new block at phase 0, where the LO is +1.
                phase <= PH_ZERO;
                cnt   <= LOG2_DECIM'(1);
                acc   <= {{(AW - PW){sample_ext[PW-1]}}, sample_ext};
            end else if (sync_i) begin
                phase <= PH_POS;
                cnt   <= '0;
                acc   <= '0;
            end else if (in_valid) begin
                phase <= phase_t'(phase + 2'd1);
                cnt   <= last ? '0 : cnt + LOG2_DECIM'(1);
                acc   <= last ? '0 : result;
            end

            // Output holding register. A load on the same edge as a consume
            // keeps out_valid high. Only a load over an unconsumed result
            // counts as an overrun.
            if (load) begin
                // The block sum is bounded by 2**(W+LOG2_DECIM-1). After the
                // shift it always fits in W bits, so truncation is exact.
                bb_o      <= W'(result >>> (LOG2_DECIM - 1));
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun_o <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demixer_decim.sv
// -----------------------------------------------------------------------------
// tb_demixer_decim
//
// Self-checking bench for demixer_decim with W=15 and DECIM=16.
//
// Each scenario pushes its expected baseband results onto a scoreboard queue.
// A monitor pops one expected value for every handshake the DUT completes and
// compares it against bb_o. The scenario tasks also check out_valid, bb_o and
// overrun_o inline at the cycles of interest.
//
// Inputs change 3 ns after each rising edge. The monitor samples on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_demixer_decim;

    localparam int W          = 15;
    localparam int LOG2_DECIM = 4;
    localparam int DECIM      = 2 ** LOG2_DECIM;

    logic                clk;
    logic                rst_n;
    logic signed [W-1:0] sample_i;
    logic                in_valid;
    logic                sync_i;
    logic signed [W-1:0] bb_o;
    logic                out_valid;
    logic                out_ready;
    logic                overrun_o;

    int vectors;
    int miscompares;

    logic signed [W-1:0] sb_q[$];

    demixer_decim #(
        .W          (W),
        .LOG2_DECIM (LOG2_DECIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_i  (sample_i),
        .in_valid  (in_valid),
        .sync_i    (sync_i),
        .bb_o      (bb_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun_o (overrun_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Scoreboard monitor. A result visible with out_valid && out_ready at
    // the falling edge is taken by the consumer on the next rising edge.
    always @(negedge clk) begin
        logic signed [W-1:0] exp_bb;
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: bb_o=%0d consumed, no result expected", bb_o);
                miscompares++;
            end else begin
                exp_bb = sb_q.pop_front();
                if (bb_o !== exp_bb) begin
                    $display("FAIL sb_data: bb_o=%0d expected %0d", bb_o, exp_bb);
                    miscompares++;
                end
            end
        end
    end

    // One input cycle: apply inputs, let a rising edge pass, return 3 ns later.
    task automatic step(input logic signed [W-1:0] s, input logic v, input logic sy);
        sample_i = s;
        in_valid = v;
        sync_i   = sy;
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        sync_i   = 1'b0;
    endtask

    function automatic logic signed [W-1:0] tone(input logic signed [W-1:0] amp, input int i);
        logic signed [W-1:0] r;
        case (i % 4)
            0:       r = amp;
            2:       r = -amp;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        sample_i  = '0;
        in_valid  = 1'b0;
        sync_i    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (bb_o !== '0 || out_valid !== 1'b0 || overrun_o !== 1'b0) begin
            $display("FAIL reset_in: bb_o=%0d out_valid=%0b overrun_o=%0b expected 0/0/0",
                     bb_o, out_valid, overrun_o);
            miscompares++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step('0, 1'b0, 1'b0);
            vectors++;
            if (bb_o !== '0 || out_valid !== 1'b0 || overrun_o !== 1'b0) begin
                $display("FAIL reset_hold: cycle %0d bb_o=%0d out_valid=%0b overrun_o=%0b expected 0/0/0",
                         i, bb_o, out_valid, overrun_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_tone();
        out_ready = 1'b1;
        // In-phase cosine of amplitude 1000 gives 8*1000 summed, 1000 after >>>3.
        sb_q.push_back(15'sd1000);
        for (int i = 0; i < DECIM; i++) begin
            step(tone(15'sd1000, i), 1'b1, 1'b0);
            if (i == DECIM - 2) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL tone_early: out_valid=%0b after sample 15, expected 0", out_valid);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd1000) begin
            $display("FAIL tone_latency: out_valid=%0b bb_o=%0d expected 1/1000", out_valid, bb_o);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL tone_pulse: out_valid=%0b after consume, expected 0", out_valid);
            miscompares++;
        end
        // A constant input averages to zero against the +1,0,-1,0 LO.
        sb_q.push_back(15'sd0);
        for (int i = 0; i < DECIM; i++) step(15'sd1000, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd0) begin
            $display("FAIL dc_reject: out_valid=%0b bb_o=%0d expected 1/0", out_valid, bb_o);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_extreme();
        logic signed [W-1:0] v;
        logic signed [W-1:0] exp_bb;
        exp_bb = -15'sd16384;
        // Per group of four the products are -16384 and -16383, so the block
        // sums to -131068. Shifting right by 3 gives floor(-16383.5) = -16384.
        sb_q.push_back(exp_bb);
        out_ready = 1'b1;
        for (int i = 0; i < DECIM; i++) begin
            case (i % 4)
                0:       v = -15'sd16384;
                2:       v = 15'sd16383;
                default: v = '0;
            endcase
            step(v, 1'b1, 1'b0);
        end
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== exp_bb) begin
            $display("FAIL extreme: out_valid=%0b bb_o=%0d expected 1/%0d", out_valid, bb_o, exp_bb);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < DECIM; i++) step(tone(15'sd1000, i), 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd1000) begin
            $display("FAIL b2b_held: out_valid=%0b bb_o=%0d expected 1/1000", out_valid, bb_o);
            miscompares++;
        end
        sb_q.push_back(15'sd1000);
        sb_q.push_back(15'sd250);
        for (int i = 0; i < DECIM - 1; i++) step(tone(15'sd250, i), 1'b1, 1'b0);
        // The held result is consumed on the same edge that loads the next one.
        out_ready = 1'b1;
        step(tone(15'sd250, DECIM - 1), 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd250 || overrun_o !== 1'b0) begin
            $display("FAIL b2b_same_edge: out_valid=%0b bb_o=%0d overrun_o=%0b expected 1/250/0",
                     out_valid, bb_o, overrun_o);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || overrun_o !== 1'b0) begin
            $display("FAIL b2b_drain: out_valid=%0b overrun_o=%0b expected 0/0", out_valid, overrun_o);
            miscompares++;
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        for (int i = 0; i < DECIM; i++) step(tone(15'sd1000, i), 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd1000 || overrun_o !== 1'b0) begin
            $display("FAIL ovr_first: out_valid=%0b bb_o=%0d overrun_o=%0b expected 1/1000/0",
                     out_valid, bb_o, overrun_o);
            miscompares++;
        end
        for (int i = 0; i < DECIM; i++) begin
            step(tone(15'sd500, i), 1'b1, 1'b0);
            if (i == DECIM / 2) begin
                vectors++;
                if (bb_o !== 15'sd1000 || out_valid !== 1'b1) begin
                    $display("FAIL ovr_stable: bb_o=%0d out_valid=%0b expected 1000/1", bb_o, out_valid);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd500 || overrun_o !== 1'b1) begin
            $display("FAIL ovr_overwrite: out_valid=%0b bb_o=%0d overrun_o=%0b expected 1/500/1",
                     out_valid, bb_o, overrun_o);
            miscompares++;
        end
        sb_q.push_back(15'sd500);
        out_ready = 1'b1;
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || overrun_o !== 1'b1) begin
            $display("FAIL ovr_sticky: out_valid=%0b overrun_o=%0b expected 0/1", out_valid, overrun_o);
            miscompares++;
        end
    endtask

    task automatic test_sync();
        out_ready = 1'b1;
        // A partial block of large DC values. It must leave no trace.
        for (int i = 0; i < 6; i++) step(15'sd5000, 1'b1, 1'b0);
        sb_q.push_back(15'sd1000);
        step(15'sd1000, 1'b1, 1'b1);
        for (int i = 1; i < DECIM; i++) begin
            step(tone(15'sd1000, i), 1'b1, 1'b0);
            if (i == 9 || i == DECIM - 2) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL sync_no_early: out_valid=%0b at post-sync sample %0d, expected 0",
                             out_valid, i);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd1000) begin
            $display("FAIL sync_valid: out_valid=%0b bb_o=%0d expected 1/1000", out_valid, bb_o);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
        // Sync without a sample: restart with an empty block.
        for (int i = 0; i < 5; i++) step(15'sd7000, 1'b1, 1'b0);
        step('0, 1'b0, 1'b1);
        sb_q.push_back(15'sd1000);
        for (int i = 0; i < DECIM; i++) step(tone(15'sd1000, i), 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd1000) begin
            $display("FAIL sync_idle: out_valid=%0b bb_o=%0d expected 1/1000", out_valid, bb_o);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_block();
        out_ready = 1'b0;
        for (int i = 0; i < DECIM; i++) step(tone(15'sd1000, i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(15'sd3000, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || bb_o !== '0 || overrun_o !== 1'b0) begin
            $display("FAIL rst_async: out_valid=%0b bb_o=%0d overrun_o=%0b expected 0/0/0",
                     out_valid, bb_o, overrun_o);
            miscompares++;
        end
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sb_q.push_back(15'sd1000);
        for (int i = 0; i < DECIM; i++) begin
            step(tone(15'sd1000, i), 1'b1, 1'b0);
            if (i == DECIM - 2) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL rst_realign_early: out_valid=%0b after sample 15, expected 0", out_valid);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || bb_o !== 15'sd1000) begin
            $display("FAIL rst_realign: out_valid=%0b bb_o=%0d expected 1/1000", out_valid, bb_o);
            miscompares++;
        end
        step('0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_tone();
        test_extreme();
        test_back_to_back();
        test_overrun();
        test_sync();
        test_reset_mid_block();
        repeat (3) step('0, 1'b0, 1'b0);
        vectors++;
        if (sb_q.size() != 0) begin
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
